// File: rtl/t48_int_seq_if.sv
// Bus between the T48 core control and the interrupt entry sequencer.
// master = core side driving status, slave = sequencer.
interface t48_int_seq_if;
  logic        en_clk_i;
  logic [2:0]  clk_mstate_i;
  logic        last_cycle_i;
  logic        int_pending_i;
  logic        ext_int_i;
  logic [11:0] pc_i;
  logic [3:0]  psw_i;
  logic [2:0]  sp_i;
  logic        busy_o;
  logic        inhibit_fetch_o;
  logic        ram_we_o;
  logic [7:0]  ram_addr_o;
  logic [7:0]  ram_data_o;
  logic        sp_inc_o;
  logic        pc_load_o;
  logic [11:0] pc_o;
  logic        int_executed_o;

  modport master (
    output en_clk_i, clk_mstate_i, last_cycle_i, int_pending_i, ext_int_i,
           pc_i, psw_i, sp_i,
    input  busy_o, inhibit_fetch_o, ram_we_o, ram_addr_o, ram_data_o,
           sp_inc_o, pc_load_o, pc_o, int_executed_o
  );

  modport slave (
    input  en_clk_i, clk_mstate_i, last_cycle_i, int_pending_i, ext_int_i,
           pc_i, psw_i, sp_i,
    output busy_o, inhibit_fetch_o, ram_we_o, ram_addr_o, ram_data_o,
           sp_inc_o, pc_load_o, pc_o, int_executed_o
  );
endinterface

// File: rtl/t48_int_seq.sv
// T48 interrupt entry: capture PC/PSW/SP, push return address to the stack
// in RAM, then load the interrupt vector into the PC.
module t48_int_seq (
  input  logic          clk_i,
  input  logic          res_i,
  t48_int_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPT    = 3'd1,
    PUSH_LO = 3'd2,
    PUSH_HI = 3'd3,
    LOAD    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] pc_q;
  logic [3:0]  psw_q;
  logic [2:0]  sp_q;
  logic [11:0] vec_q;
  logic        trig;
  logic [7:0]  stk_base;

  // Only the final state of the last machine cycle may start entry.
  assign trig = (state_q == IDLE) && bus.int_pending_i && bus.last_cycle_i &&
                (bus.clk_mstate_i == 3'b100);

  // Stack frame for level n lives at 8'h08 + 2n; sp_q <= 7 keeps it below 8'h18.
  assign stk_base = 8'h08 + {4'b0000, sp_q, 1'b0};

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      psw_q   <= '0;
      sp_q    <= '0;
      vec_q   <= '0;
    end else if (bus.en_clk_i) begin
      state_q <= state_d;
      if (trig) begin
        pc_q  <= bus.pc_i;
        psw_q <= bus.psw_i;
        sp_q  <= bus.sp_i;
        vec_q <= bus.ext_int_i ? 12'h003 : 12'h007;
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    bus.busy_o          = 1'b1;
    bus.inhibit_fetch_o = 1'b0;
    bus.ram_we_o        = 1'b0;
    bus.ram_addr_o      = '0;
    bus.ram_data_o      = '0;
    bus.sp_inc_o        = 1'b0;
    bus.pc_load_o       = 1'b0;
    bus.pc_o            = '0;
    bus.int_executed_o  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.busy_o = 1'b0;
        if (trig) state_d = CAPT;
      end
      CAPT: begin
        bus.inhibit_fetch_o = bus.en_clk_i;
        state_d             = PUSH_LO;
      end
      PUSH_LO: begin
        bus.ram_we_o   = bus.en_clk_i;
        bus.ram_addr_o = stk_base;
        bus.ram_data_o = pc_q[7:0];
        state_d        = PUSH_HI;
      end
      PUSH_HI: begin
        bus.ram_we_o   = bus.en_clk_i;
        bus.ram_addr_o = stk_base + 8'h01;
        bus.ram_data_o = {psw_q, pc_q[11:8]};
        bus.sp_inc_o   = bus.en_clk_i;
        state_d        = LOAD;
      end
      LOAD: begin
        bus.pc_load_o      = bus.en_clk_i;
        bus.int_executed_o = bus.en_clk_i;
        bus.pc_o           = vec_q;
        state_d            = IDLE;
      end
      default: begin
        bus.busy_o = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_t48_int_seq.sv
// Scoreboard bench for t48_int_seq: expected RAM writes, SP increments and
// vector loads are queued at trigger time and popped as the DUT strobes them.
module tb_t48_int_seq;

  logic clk_i = 1'b0;
  logic res_i = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  t48_int_seq_if bus();

  t48_int_seq u_dut (.clk_i(clk_i), .res_i(res_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  // {kind[3:0], payload[19:0]}: 1 = ram write {addr,data}, 2 = sp_inc, 3 = exec pc
  logic [23:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic sb_pop(input string tag, input logic [23:0] obs);
    logic [23:0] e;
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
    chk(tag, {40'd0, obs}, {40'd0, e});
  endtask

  function automatic logic [33:0] all_out();
    return {bus.busy_o, bus.inhibit_fetch_o, bus.ram_we_o, bus.ram_addr_o,
            bus.ram_data_o, bus.sp_inc_o, bus.pc_load_o, bus.pc_o,
            bus.int_executed_o};
  endfunction

  always @(negedge clk_i) begin
    if (bus.ram_we_o)       sb_pop("ram_wr", {4'd1, 4'd0, bus.ram_addr_o, bus.ram_data_o});
    if (bus.sp_inc_o)       sb_pop("sp_inc", {4'd2, 20'd0});
    if (bus.int_executed_o) begin
      sb_pop("int_exec", {4'd3, 8'd0, bus.pc_o});
      chk("pc_load_w_exec", {63'd0, bus.pc_load_o}, 64'd1);
    end
    if (!bus.en_clk_i)
      chk("gated_strobes", {59'd0, bus.inhibit_fetch_o, bus.ram_we_o, bus.sp_inc_o,
                            bus.pc_load_o, bus.int_executed_o}, 64'd0);
    if (!bus.busy_o)
      chk("idle_bus", {36'd0, bus.ram_addr_o, bus.ram_data_o, bus.pc_o}, 64'd0);
  end

  task automatic idle_inputs();
    bus.en_clk_i      = 1'b1;
    bus.clk_mstate_i  = 3'b000;
    bus.last_cycle_i  = 1'b0;
    bus.int_pending_i = 1'b0;
    bus.ext_int_i     = 1'b0;
    bus.pc_i          = '0;
    bus.psw_i         = '0;
    bus.sp_i          = '0;
  endtask

  task automatic expect_seq(input logic ext, input logic [11:0] pc, input logic [3:0] psw,
                            input logic [2:0] sp);
    logic [7:0] a;
    a = 8'(8 + 2 * int'(sp));
    sb.push_back({4'd1, 4'd0, a, pc[7:0]});
    sb.push_back({4'd1, 4'd0, a + 8'd1, psw, pc[11:8]});
    sb.push_back({4'd2, 20'd0});
    sb.push_back({4'd3, 8'd0, (ext ? 12'h003 : 12'h007)});
  endtask

  // Fire a trigger, then scramble the inputs while busy to show they are ignored.
  task automatic trigger(input logic ext, input logic [11:0] pc, input logic [3:0] psw,
                         input logic [2:0] sp, input logic hold);
    bus.en_clk_i = 1'b1; bus.int_pending_i = 1'b1; bus.last_cycle_i = 1'b1;
    bus.clk_mstate_i = 3'b100; bus.ext_int_i = ext;
    bus.pc_i = pc; bus.psw_i = psw; bus.sp_i = sp;
    @(posedge clk_i); #1;
    chk("busy_after_trig", {63'd0, bus.busy_o}, 64'd1);
    bus.int_pending_i = hold; bus.last_cycle_i = 1'b0;
    bus.ext_int_i = ~ext; bus.pc_i = ~pc; bus.psw_i = ~psw; bus.sp_i = ~sp;
  endtask

  task automatic run_seq(input logic ext, input logic [11:0] pc, input logic [3:0] psw,
                         input logic [2:0] sp, input logic gappy, input logic hold);
    int en_cnt, inh_cnt;
    logic done;
    en_cnt = 0; inh_cnt = 0; done = 1'b0;
    expect_seq(ext, pc, psw, sp);
    trigger(ext, pc, psw, sp, hold);
    for (int c = 0; c < 20 && !done; c++) begin
      bus.en_clk_i = gappy ? (c % 2 == 0) : 1'b1;
      @(negedge clk_i);
      if (bus.en_clk_i) en_cnt++;
      if (bus.inhibit_fetch_o) inh_cnt++;
      if (bus.int_executed_o) done = 1'b1;
      @(posedge clk_i); #1;
    end
    chk("exec_seen", {63'd0, done}, 64'd1);
    chk("latency_en_cycles", 64'(en_cnt), 64'd4);
    chk("inhibit_cnt", 64'(inh_cnt), 64'd1);
    chk("busy_after_seq", {63'd0, bus.busy_o}, 64'd0);
    bus.en_clk_i = 1'b1;
  endtask

  initial begin
    idle_inputs();
    #2;
    chk("reset_outputs", {30'd0, all_out()}, 64'd0);
    @(posedge clk_i); #1;
    res_i = 1'b0;
    @(posedge clk_i); #1;
    chk("idle_after_rst", {63'd0, bus.busy_o}, 64'd0);

    // pending but not at the end of the instruction / machine cycle
    bus.int_pending_i = 1'b1; bus.last_cycle_i = 1'b0; bus.clk_mstate_i = 3'b100;
    repeat (2) @(posedge clk_i); #1;
    chk("no_trig_last0", {63'd0, bus.busy_o}, 64'd0);
    bus.last_cycle_i = 1'b1; bus.clk_mstate_i = 3'b011;
    repeat (2) @(posedge clk_i); #1;
    chk("no_trig_mstate3", {63'd0, bus.busy_o}, 64'd0);
    idle_inputs();
    @(posedge clk_i); #1;

    run_seq(1'b1, 12'hA5C, 4'h9, 3'd2, 1'b0, 1'b0);
    run_seq(1'b0, 12'h123, 4'h0, 3'd7, 1'b0, 1'b0);
    run_seq(1'b1, 12'hA5C, 4'h9, 3'd2, 1'b1, 1'b0);

    // pending held throughout: one pulse, no retrigger until last_cycle returns
    run_seq(1'b0, 12'h3FF, 4'hF, 3'd5, 1'b0, 1'b1);
    repeat (3) @(posedge clk_i); #1;
    chk("no_retrigger", {63'd0, bus.busy_o}, 64'd0);
    run_seq(1'b1, 12'h456, 4'h3, 3'd1, 1'b0, 1'b0);

    // reset during PUSH_LO: only the low-byte write may appear
    sb.push_back({4'd1, 4'd0, 8'h0A, 8'hBC});
    trigger(1'b1, 12'h7BC, 4'h5, 3'd1, 1'b1);
    @(posedge clk_i); #1;
    @(negedge clk_i); #1;
    res_i = 1'b1;
    #1;
    chk("rst_mid_outputs", {30'd0, all_out()}, 64'd0);
    @(posedge clk_i); #1;
    idle_inputs();
    res_i = 1'b0;
    repeat (4) @(posedge clk_i); #1;
    chk("rst_mid_idle", {63'd0, bus.busy_o}, 64'd0);
    chk("sb_drained_rst", 64'(sb.size()), 64'd0);
    sb.delete();

    run_seq(1'b0, 12'h800, 4'h4, 3'd0, 1'b0, 1'b0);
    idle_inputs();
    repeat (3) @(posedge clk_i); #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
